// File: rtl/riscv_pkg.sv
// Shared types for the RV32I pipeline.
//   result_src_t : writeback source select (ALU, data memory, PC+4)
//   fwd_sel_t    : E-stage operand source select
//   ctrl_e_t     : control bundle carried from D into E
//   REG_ZERO     : index of the hard-wired zero register
package riscv_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic        reg_write;
        result_src_t result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic [2:0]  alu_ctrl;
        logic        alu_src;
        logic        pred_taken;
    } ctrl_e_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Combinational hazard logic for the D/E boundary.
//   Inputs : D source indices and valid, E destination/sources/result source,
//            flush from E, M/W destinations and write enables.
//   Outputs: lu (load-use detected), stall_f/stall_d, forward_a_e/forward_b_e.
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              valid_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              valid_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  result_src_t       result_src_e,
    input  logic              flush_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic              lu,
    output logic              stall_f,
    output logic              stall_d,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e
);

    localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

    // M is the younger producer, so it wins over W; x0 never forwards.
    function automatic fwd_sel_t fwd_sel(input logic [REG_AW-1:0] rs);
        if (reg_write_m && rd_m != ZERO && rd_m == rs)
            return FWD_M;
        else if (reg_write_w && rd_w != ZERO && rd_w == rs)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    // rs2_d is compared even for I-type instructions: a spurious stall is
    // harmless, and it avoids decoding the format here.
    assign lu = valid_d && valid_e && (result_src_e == RES_MEM) &&
                (rd_e != ZERO) && (rd_e == rs1_d || rd_e == rs2_d);

    // A flush redirects fetch, so it must not be held by a stall.
    assign stall_f = lu && !flush_e;
    assign stall_d = lu && !flush_e;

    assign forward_a_e = fwd_sel(rs1_e);
    assign forward_b_e = fwd_sel(rs2_e);

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register of the RV32I core.
//   Inputs : D-stage data/indices/control (valid_d, rd1_d, rd2_d, rs1_d, rs2_d,
//            rd_d, imm_ext_d, pc_d, pc_plus4_d, ctrl_d), flush_e from E,
//            M/W destinations and write enables for forwarding.
//   Outputs: registered E copies (valid_e, rd1_e, rd2_e, imm_ext_e, pc_e,
//            pc_plus4_e, rs1_e, rs2_e, rd_e, ctrl_e), stall_f/stall_d,
//            forward_a_e/forward_b_e, saturating stall_count/flush_count.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_d,
    input  logic [XLEN-1:0]   rd1_d,
    input  logic [XLEN-1:0]   rd2_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic [XLEN-1:0]   imm_ext_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   pc_plus4_d,
    input  ctrl_e_t           ctrl_d,
    input  logic              flush_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic              valid_e,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   imm_ext_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pc_plus4_e,
    output logic [REG_AW-1:0] rs1_e,
    output logic [REG_AW-1:0] rs2_e,
    output logic [REG_AW-1:0] rd_e,
    output ctrl_e_t           ctrl_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    logic lu;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    hazard_unit #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .valid_d      (valid_d),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .valid_e      (valid_e),
        .rd_e         (rd_e),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .result_src_e (ctrl_e.result_src),
        .flush_e      (flush_e),
        .rd_m         (rd_m),
        .rd_w         (rd_w),
        .reg_write_m  (reg_write_m),
        .reg_write_w  (reg_write_w),
        .lu           (lu),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e)
    );

    // ---- D -> E register boundary ----
    // A bubble is an all-zero E: cleared control makes it a NOP.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_e     <= 1'b0;
            rd1_e       <= '0;
            rd2_e       <= '0;
            imm_ext_e   <= '0;
            pc_e        <= '0;
            pc_plus4_e  <= '0;
            rs1_e       <= '0;
            rs2_e       <= '0;
            rd_e        <= '0;
            ctrl_e      <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (flush_e || lu) begin
            valid_e    <= 1'b0;
            rd1_e      <= '0;
            rd2_e      <= '0;
            imm_ext_e  <= '0;
            pc_e       <= '0;
            pc_plus4_e <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
            ctrl_e     <= '0;
            // Flush dominates: a simultaneous load-use is not counted as a stall.
            if (flush_e)
                flush_count <= sat_inc(flush_count);
            else
                stall_count <= sat_inc(stall_count);
        end else begin
            valid_e    <= valid_d;
            rd1_e      <= rd1_d;
            rd2_e      <= rd2_d;
            imm_ext_e  <= imm_ext_d;
            pc_e       <= pc_d;
            pc_plus4_e <= pc_plus4_d;
            rs1_e      <= rs1_d;
            rs2_e      <= rs2_d;
            rd_e       <= rd_d;
            ctrl_e     <= ctrl_d;
        end
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute boundary of the pipelined, branch-predicted RV32I core.
- Registers register-file read data (rd1/rd2), immediate, PC and control from D into E.
- Detects load-use hazards and generates F/D stalls and an E bubble.
- Inserts a bubble on branch-mispredict flush, produces E-stage forwarding selects, and keeps stall/flush performance counters.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  synchronous reset, active-low
valid_d  in  1  D holds a real instruction
rd1_d, rd2_d  in  XLEN  register-file read data
rs1_d, rs2_d, rd_d  in  REG_AW  source/destination indices
imm_ext_d, pc_d, pc_plus4_d  in  XLEN  immediate, PC, PC+4
ctrl_d  in  ctrl_e_t  control bundle: reg_write, result_src[1:0], mem_write, jump, branch, alu_ctrl[2:0], alu_src, pred_taken
flush_e  in  1  mispredict/redirect from E: bubble E
rd_m, rd_w  in  REG_AW  destinations in M/W
reg_write_m, reg_write_w  in  1  M/W write enables
valid_e  out  1  E holds a real instruction
rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e  out  XLEN  registered copies
rs1_e, rs2_e, rd_e  out  REG_AW  registered indices
ctrl_e  out  ctrl_e_t  registered control
stall_f, stall_d  out  1  hold PC and IF/ID register
forward_a_e, forward_b_e  out  2  operand source: 00 regfile, 01 W result, 10 M ALU result
stall_count, flush_count  out  CNT_W  saturating event counters

Behaviour:
Reset:
- reset_n low at a rising edge clears every registered output to 0, including valid_e, ctrl_e and both counters.
- A cleared ctrl_e is a NOP: reg_write, mem_write, branch and jump are all 0.
- Mid-operation reset overrides flush and hazard. In that cycle stall_f/stall_d are still computed from the pre-reset E contents; the next cycle they are 0.

Load-use hazard (combinational):
- lu = valid_d & valid_e & ctrl_e.result_src==RES_MEM & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
- The comparison is conservative: it uses rs2_d even for I-type instructions. This is intended.

Stall outputs:
- stall_f = stall_d = lu & ~flush_e. A flush suppresses the stall so fetch redirects.

Register update each rising edge, reset_n high, in priority order:
1. flush_e: bubble. valid_e=0, ctrl_e=0, data fields 0. flush_count +1.
2. lu: bubble, same contents as above. stall_count +1.
3. Otherwise: capture all D fields; valid_e=valid_d.

Flush and lu together:
- Bubble; flush_count increments, stall_count does not.

Counters:
- Saturate at all-ones; no wrap.

Forwarding (combinational from registered E indices):
- forward_a_e = 10 if reg_write_m & rd_m!=0 & rd_m==rs1_e.
- Else 01 if reg_write_w & rd_w!=0 & rd_w==rs1_e.
- Else 00.
- M takes priority over W. forward_b_e uses rs2_e identically.
- x0 is never forwarded.

W-to-D bypass:
- Not required. The register file writes on the falling clock edge, so rd1_d/rd2_d already reflect a same-cycle W write.

Latency:
- One cycle D to E. A load-use stall costs exactly one bubble.

Decomposition:
- Package riscv_pkg:
  - ctrl_e_t packed struct (field order as listed in Ports).
  - result_src enum: RES_ALU=00, RES_MEM=01, RES_PC4=10.
  - fwd_sel enum: FWD_RF=00, FWD_W=01, FWD_M=10.
  - REG_ZERO constant.
- Sub-module hazard_unit:
  - Purely combinational.
  - Computes lu, stall_f, stall_d, forward_a_e, forward_b_e.
  - id_ex_stage holds all registers and counters.

Test Plan:
- Reset: hold reset_n=0 two cycles with valid_d=1, rd_d=5, reg_write=1 -> all outputs 0, valid_e=0, counters 0. Release -> next edge captures D.
- Load-use: E=lw x5, D=add x6,x5,x1 -> stall_f=stall_d=1 for one cycle; E becomes a bubble (reg_write_e=0); stall_count=1. The following edge captures the add with rs1_e=5.
- x0 load: E=lw x0, D uses x0 -> no stall, stall_count unchanged.
- Flush with hazard: flush_e=1 while lu=1 -> stall_f=0, E bubble, flush_count=1, stall_count=0.
- Forward priority: rs1_e=7, rd_m=7/reg_write_m=1, rd_w=7/reg_write_w=1 -> forward_a_e=10. Drop reg_write_m -> 01. Set rd_m=rd_w=0 with rs1_e=0 -> 00.
- Saturation: preload stall_count to all-ones minus 1 (CNT_W=4: 14), apply three load-use events -> 15, 15, 15.
